// File: rtl/capture_readout_ctrl_if.sv
// Sample stream from the readout sequencer to the host link (valid/ready).
interface capture_readout_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/capture_readout_ctrl.sv
// Clears and arms one ADC capture, waits for done, then streams the sample RAM
// out over valid/ready while tracking min/max of the 12-bit ADC field.
module capture_readout_ctrl #(
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned NUM_SAMPLES    = 1023,
    parameter int unsigned CLEAR_CYCLES   = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    output logic                   o_cap_reset_n,
    output logic                   o_cap_start,
    input  logic                   i_cap_done,
    output logic [ADDR_WIDTH-1:0]  o_rd_addr,
    input  logic [DATA_WIDTH-1:0]  i_rd_data,
    capture_readout_ctrl_if.master o_stream,
    output logic                   o_busy,
    output logic                   o_error,
    output logic [11:0]            o_peak_max,
    output logic [11:0]            o_peak_min
);
    localparam int unsigned W_TMO = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned W_CLR = $clog2(CLEAR_CYCLES + 1);
    localparam int unsigned W_MAX = (W_TMO > W_CLR) ? W_TMO : W_CLR;
    localparam int unsigned CNT_W = (W_MAX > 20) ? W_MAX : 20;
    localparam logic [CNT_W-1:0]      CLR_LOAD  = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0]      TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_SAMPLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_ARM, S_FETCH, S_LOAD, S_SEND, S_FINISH
    } state_t;

    state_t                r_state, w_state_nxt;
    logic                  r_done_meta, r_done_s;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic                  r_cap_reset_n, w_cap_reset_n_nxt;
    logic                  r_cap_start, w_cap_start_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_error, w_error_nxt;
    logic [ADDR_WIDTH-1:0] r_rd_addr, w_rd_addr_nxt;
    logic [DATA_WIDTH-1:0] r_out_data, w_out_data_nxt;
    logic                  r_out_valid, w_out_valid_nxt;
    logic                  r_out_last, w_out_last_nxt;
    logic [11:0]           r_peak_max, w_peak_max_nxt;
    logic [11:0]           r_peak_min, w_peak_min_nxt;
    logic [11:0]           w_adc;
    logic                  w_accept;
    logic                  w_timeout;

    assign w_adc     = i_rd_data[11:0];
    assign w_accept  = r_out_valid & o_stream.out_ready;
    assign w_timeout = (r_cnt == TMO_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // done wins over timeout when both land in the same ARM cycle
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:   if (i_start) w_state_nxt = S_CLEAR;
            S_CLEAR:  if (r_cnt == '0) w_state_nxt = S_ARM;
            S_ARM: begin
                if (r_done_s)       w_state_nxt = S_FETCH;
                else if (w_timeout) w_state_nxt = S_IDLE;
            end
            S_FETCH:  w_state_nxt = S_LOAD;
            S_LOAD:   w_state_nxt = S_SEND;
            S_SEND:   if (w_accept) w_state_nxt = r_out_last ? S_FINISH : S_FETCH;
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_nxt       = r_cnt;
        w_rd_addr_nxt   = r_rd_addr;
        w_out_data_nxt  = r_out_data;
        w_out_valid_nxt = r_out_valid;
        w_out_last_nxt  = r_out_last;
        w_error_nxt     = r_error;
        w_peak_max_nxt  = r_peak_max;
        w_peak_min_nxt  = r_peak_min;
        unique case (r_state)
            S_IDLE: if (i_start) begin
                w_cnt_nxt      = CLR_LOAD;
                w_error_nxt    = 1'b0;
                w_peak_max_nxt = '0;
                w_peak_min_nxt = '1;
            end
            S_CLEAR: w_cnt_nxt = (r_cnt == '0) ? '0 : r_cnt - 1'b1;
            S_ARM: begin
                if (r_done_s)       w_rd_addr_nxt = '0;
                else if (w_timeout) w_error_nxt   = 1'b1;
                else                w_cnt_nxt     = r_cnt + 1'b1;
            end
            S_LOAD: begin
                w_out_data_nxt  = i_rd_data;
                w_out_valid_nxt = 1'b1;
                w_out_last_nxt  = (r_rd_addr == LAST_ADDR);
                if (w_adc > r_peak_max) w_peak_max_nxt = w_adc;
                if (w_adc < r_peak_min) w_peak_min_nxt = w_adc;
            end
            S_SEND: if (w_accept) begin
                w_out_valid_nxt = 1'b0;
                w_out_last_nxt  = 1'b0;
                if (!r_out_last) w_rd_addr_nxt = r_rd_addr + 1'b1;
            end
            default: ;
        endcase
        // capture-stage controls follow the state being entered so they stay registered
        w_cap_reset_n_nxt = !((w_state_nxt == S_CLEAR) || (w_state_nxt == S_FINISH));
        w_cap_start_nxt   = (w_state_nxt == S_ARM) || (w_state_nxt == S_FETCH) ||
                            (w_state_nxt == S_LOAD) || (w_state_nxt == S_SEND);
        w_busy_nxt        = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_done_meta   <= 1'b0;
            r_done_s      <= 1'b0;
            r_cnt         <= '0;
            r_cap_reset_n <= 1'b0;
            r_cap_start   <= 1'b0;
            r_busy        <= 1'b0;
            r_error       <= 1'b0;
            r_rd_addr     <= '0;
            r_out_data    <= '0;
            r_out_valid   <= 1'b0;
            r_out_last    <= 1'b0;
            r_peak_max    <= '0;
            r_peak_min    <= '1;
        end else begin
            r_done_meta   <= i_cap_done;
            r_done_s      <= r_done_meta;
            r_cnt         <= w_cnt_nxt;
            r_cap_reset_n <= w_cap_reset_n_nxt;
            r_cap_start   <= w_cap_start_nxt;
            r_busy        <= w_busy_nxt;
            r_error       <= w_error_nxt;
            r_rd_addr     <= w_rd_addr_nxt;
            r_out_data    <= w_out_data_nxt;
            r_out_valid   <= w_out_valid_nxt;
            r_out_last    <= w_out_last_nxt;
            r_peak_max    <= w_peak_max_nxt;
            r_peak_min    <= w_peak_min_nxt;
        end
    end

    assign o_cap_reset_n      = r_cap_reset_n;
    assign o_cap_start        = r_cap_start;
    assign o_busy             = r_busy;
    assign o_error            = r_error;
    assign o_rd_addr          = r_rd_addr;
    assign o_stream.out_data  = r_out_data;
    assign o_stream.out_valid = r_out_valid;
    assign o_stream.out_last  = r_out_last;
    assign o_peak_max         = r_peak_max;
    assign o_peak_min         = r_peak_min;
endmodule

// File: tb/tb_capture_readout_ctrl.sv
// Bench for capture_readout_ctrl: sync-RAM and capture-stage models, a stream
// monitor, and expectations derived directly from the RAM contents.
module tb_capture_readout_ctrl;
    localparam int unsigned AW  = 10;
    localparam int unsigned DW  = 16;
    localparam int unsigned NS  = 1023;
    localparam int unsigned CLR = 8;
    localparam int unsigned TMO = 100;
    localparam int          NSI = int'(NS);

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          cap_reset_n, cap_start;
    logic          cap_done = 1'b0;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic          busy, error;
    logic [11:0]   peak_max, peak_min;
    logic [DW-1:0] mem [0:(1<<AW)-1];
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            done_delay = 0;
    int            cs_cnt = 0;

    capture_readout_ctrl_if #(.DATA_WIDTH(DW)) s_if ();

    capture_readout_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SAMPLES(NS),
        .CLEAR_CYCLES(CLR), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .o_cap_reset_n(cap_reset_n), .o_cap_start(cap_start), .i_cap_done(cap_done),
        .o_rd_addr(rd_addr), .i_rd_data(rd_data), .o_stream(s_if),
        .o_busy(busy), .o_error(error), .o_peak_max(peak_max), .o_peak_min(peak_min)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rd_data <= mem[rd_addr];

    // capture stage: raises done done_delay cycles into cap_start, cleared by cap_reset_n
    always begin
        @(posedge clk);
        #2;
        if (cap_reset_n === 1'b0) begin
            cs_cnt = 0;
            cap_done = 1'b0;
        end else if (cap_start === 1'b1 && done_delay > 0) begin
            cs_cnt++;
            if (cs_cnt >= done_delay) cap_done = 1'b1;
        end
    end

    bit            mon_en = 1'b0;
    logic [DW-1:0] beat_q [$];
    bit            last_q [$];
    int            tcyc_q [$];
    int            low_runs [$];
    int            lowrun, stab_viol, bad_combo, done_cyc, first_cyc, cs_cyc, err_cyc;
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    always @(negedge clk) begin
        if (mon_en) begin
            if (s_if.out_valid === 1'b1 && s_if.out_ready === 1'b1) begin
                beat_q.push_back(s_if.out_data);
                last_q.push_back(s_if.out_last === 1'b1);
                tcyc_q.push_back(cyc);
            end
            if (prev_stall && (s_if.out_valid !== 1'b1 || s_if.out_data !== prev_data ||
                               s_if.out_last !== prev_last)) stab_viol++;
            prev_stall = (s_if.out_valid === 1'b1) && (s_if.out_ready !== 1'b1);
            prev_data  = s_if.out_data;
            prev_last  = s_if.out_last;
            if (cap_reset_n === 1'b0) lowrun++;
            else if (lowrun != 0) begin
                low_runs.push_back(lowrun);
                lowrun = 0;
            end
            if ((cap_start && !cap_reset_n) || (s_if.out_valid && !cap_start) || (cap_start && !busy))
                bad_combo++;
            if (cap_done === 1'b1 && done_cyc < 0) done_cyc = cyc;
            if (s_if.out_valid === 1'b1 && first_cyc < 0) first_cyc = cyc;
            if (cap_start === 1'b1 && cs_cyc < 0) cs_cyc = cyc;
            if (error === 1'b1 && err_cyc < 0) err_cyc = cyc;
        end
    end

    task automatic clear_mon();
        beat_q.delete(); last_q.delete(); tcyc_q.delete(); low_runs.delete();
        lowrun = 0; stab_viol = 0; bad_combo = 0; prev_stall = 1'b0;
        done_cyc = -1; first_cyc = -1; cs_cyc = -1; err_cyc = -1;
    endtask

    // Reference: the stream must be mem[0..NS-1] in order with last only on the final word.
    function automatic int stream_bad(output int first);
        int n = 0;
        first = -1;
        for (int i = 0; i < beat_q.size(); i++) begin
            if (i >= NSI || beat_q[i] !== mem[i] || last_q[i] != (i == NSI - 1)) begin
                n++;
                if (first < 0) first = i;
            end
        end
        return n;
    endfunction

    function automatic void model_peaks(output logic [11:0] mx, output logic [11:0] mn);
        mx = 12'h000;
        mn = 12'hFFF;
        for (int i = 0; i < NSI; i++) begin
            logic [11:0] v;
            v = mem[i][11:0];
            if (v > mx) mx = v;
            if (v < mn) mn = v;
        end
    endfunction

    function automatic int spacing_bad();
        int n = 0;
        for (int i = 1; i < tcyc_q.size(); i++) if (tcyc_q[i] - tcyc_q[i-1] != 3) n++;
        return n;
    endfunction

    function automatic int lr(input int idx);
        return (idx < low_runs.size()) ? low_runs[idx] : -1;
    endfunction

    task automatic run_capture(input bit rnd_ready, input int inj_at, input int rst_at,
                               output logic err_at_start, output logic busy_at_start);
        bit injected = 1'b0;
        bit done_ok = 1'b0;
        clear_mon();
        mon_en = 1'b1;
        s_if.out_ready = 1'b1;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        err_at_start  = error;
        busy_at_start = busy;
        for (int c = 0; c < 20000; c++) begin
            if (rst_at >= 0 && beat_q.size() >= rst_at) begin
                rst_n = 1'b0;
                done_ok = 1'b1;
                break;
            end
            if (busy !== 1'b1) begin
                done_ok = 1'b1;
                break;
            end
            start = 1'b0;
            s_if.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (inj_at >= 0 && !injected && beat_q.size() >= inj_at && s_if.out_valid === 1'b1) begin
                start = 1'b1;
                injected = 1'b1;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        s_if.out_ready = 1'b1;
        if (rst_at < 0) begin @(negedge clk); #1; end
        mon_en = 1'b0;
        checks++;
        if (done_ok !== 1'b1) begin
            errors++;
            $display("FAIL run_budget: busy=%b after 20000 cycles, required 0", busy);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (cap_reset_n !== 1'b0) begin errors++; $display("FAIL rst_cap_reset_n: got %b want 0", cap_reset_n); end
        checks++; if (cap_start !== 1'b0) begin errors++; $display("FAIL rst_cap_start: got %b want 0", cap_start); end
        checks++; if (rd_addr !== '0) begin errors++; $display("FAIL rst_rd_addr: got %h want 0", rd_addr); end
        checks++; if (s_if.out_data !== '0) begin errors++; $display("FAIL rst_out_data: got %h want 0", s_if.out_data); end
        checks++; if ({s_if.out_valid, s_if.out_last, busy, error} !== 4'b0000) begin errors++;
            $display("FAIL rst_flags: valid/last/busy/error got %b want 0000", {s_if.out_valid, s_if.out_last, busy, error}); end
        checks++; if (peak_max !== 12'h000) begin errors++; $display("FAIL rst_peak_max: got %h want 000", peak_max); end
        checks++; if (peak_min !== 12'hFFF) begin errors++; $display("FAIL rst_peak_min: got %h want fff", peak_min); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (cap_reset_n !== 1'b1) begin errors++; $display("FAIL idle_cap_reset_n: got %b want 1", cap_reset_n); end
    endtask

    task automatic test_full_stream();
        logic e0, b0;
        int fb, nb;
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);
        done_delay = 50;
        run_capture(1'b0, -1, -1, e0, b0);
        nb = stream_bad(fb);
        checks++; if (beat_q.size() != NSI) begin errors++; $display("FAIL full_count: got %0d want %0d", beat_q.size(), NSI); end
        checks++; if (nb != 0) begin errors++; $display("FAIL full_stream: bad beats %0d want 0 (first idx %0d)", nb, fb); end
        checks++; if (spacing_bad() != 0) begin errors++; $display("FAIL full_spacing: irregular gaps %0d want 0", spacing_bad()); end
        checks++; if (first_cyc - done_cyc != 5) begin errors++; $display("FAIL first_latency: got %0d want 5", first_cyc - done_cyc); end
        checks++; if (low_runs.size() != 2 || lr(0) != int'(CLR) || lr(1) != 1) begin errors++;
            $display("FAIL cap_reset_lows: runs=%0d first=%0d second=%0d want 2,%0d,1", low_runs.size(), lr(0), lr(1), CLR); end
        checks++; if (peak_max !== 12'h3FE) begin errors++; $display("FAIL full_peak_max: got %h want 3fe", peak_max); end
        checks++; if (peak_min !== 12'h000) begin errors++; $display("FAIL full_peak_min: got %h want 000", peak_min); end
        checks++; if ({busy, cap_start, cap_reset_n, error} !== 4'b0010) begin errors++;
            $display("FAIL full_end_idle: busy/start/rstn/err got %b want 0010", {busy, cap_start, cap_reset_n, error}); end
        checks++; if (bad_combo != 0) begin errors++; $display("FAIL full_combo: got %0d want 0", bad_combo); end
    endtask

    task automatic test_random_ready();
        logic e0, b0;
        logic [11:0] mx, mn;
        int fb, nb;
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
        model_peaks(mx, mn);
        run_capture(1'b1, 200, -1, e0, b0);
        nb = stream_bad(fb);
        checks++; if (beat_q.size() != NSI) begin errors++; $display("FAIL rnd_count: got %0d want %0d", beat_q.size(), NSI); end
        checks++; if (nb != 0) begin errors++; $display("FAIL rnd_stream: bad beats %0d want 0 (first idx %0d)", nb, fb); end
        checks++; if (stab_viol != 0) begin errors++; $display("FAIL rnd_stall_stable: got %0d changes want 0", stab_viol); end
        checks++; if (low_runs.size() != 2) begin errors++; $display("FAIL rnd_start_ignored: reset runs %0d want 2", low_runs.size()); end
        checks++; if (peak_max !== mx || peak_min !== mn) begin errors++;
            $display("FAIL rnd_peaks: got %h/%h want %h/%h", peak_max, peak_min, mx, mn); end
        checks++; if (bad_combo != 0) begin errors++; $display("FAIL rnd_combo: got %0d want 0", bad_combo); end
    endtask

    task automatic test_timeout();
        logic e0, b0;
        done_delay = 0;
        run_capture(1'b0, -1, -1, e0, b0);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL tmo_error: got %b want 1", error); end
        checks++; if ({busy, cap_start} !== 2'b00) begin errors++; $display("FAIL tmo_idle: busy/start got %b want 00", {busy, cap_start}); end
        checks++; if (err_cyc - cs_cyc != int'(TMO)) begin errors++; $display("FAIL tmo_cycles: got %0d want %0d", err_cyc - cs_cyc, TMO); end
        checks++; if (first_cyc != -1 || beat_q.size() != 0) begin errors++; $display("FAIL tmo_no_valid: beats %0d want 0", beat_q.size()); end
        checks++; if (low_runs.size() != 1) begin errors++; $display("FAIL tmo_reset_runs: got %0d want 1", low_runs.size()); end
    endtask

    task automatic test_error_clear_start_busy();
        logic e0, b0;
        int fb, nb;
        done_delay = 50;
        run_capture(1'b0, 500, -1, e0, b0);
        nb = stream_bad(fb);
        checks++; if ({e0, b0} !== 2'b01) begin errors++; $display("FAIL err_clear: error/busy got %b want 01", {e0, b0}); end
        checks++; if (beat_q.size() != NSI || nb != 0) begin errors++;
            $display("FAIL busy_start_stream: beats %0d bad %0d want %0d,0", beat_q.size(), nb, NSI); end
        checks++; if (low_runs.size() != 2 || error !== 1'b0) begin errors++;
            $display("FAIL busy_start_ignored: runs %0d err %b want 2,0", low_runs.size(), error); end
    endtask

    task automatic test_peaks();
        logic e0, b0;
        int fb, nb;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 16'h0800;
        mem[5] = 16'h0FFF;
        mem[9] = 16'hF123;
        run_capture(1'b0, -1, -1, e0, b0);
        nb = stream_bad(fb);
        repeat (10) @(posedge clk);
        #1;
        checks++; if (nb != 0) begin errors++; $display("FAIL pk_stream: bad beats %0d want 0", nb); end
        checks++; if (peak_max !== 12'hFFF) begin errors++; $display("FAIL pk_max: got %h want fff", peak_max); end
        checks++; if (peak_min !== 12'h123) begin errors++; $display("FAIL pk_min: got %h want 123", peak_min); end
    endtask

    task automatic test_reset_mid();
        logic e0, b0;
        int fb, nb;
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);
        run_capture(1'b0, -1, 300, e0, b0);
        #1;
        checks++; if ({s_if.out_valid, cap_reset_n, busy, cap_start} !== 4'b0000) begin errors++;
            $display("FAIL mid_reset: valid/rstn/busy/start got %b want 0000", {s_if.out_valid, cap_reset_n, busy, cap_start}); end
        checks++; if (rd_addr !== '0) begin errors++; $display("FAIL mid_reset_addr: got %h want 0", rd_addr); end
        nb = stream_bad(fb);
        checks++; if (beat_q.size() != 300 || nb != 0) begin errors++;
            $display("FAIL mid_prefix: beats %0d bad %0d want 300,0", beat_q.size(), nb); end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        run_capture(1'b0, -1, -1, e0, b0);
        nb = stream_bad(fb);
        checks++; if (beat_q.size() != NSI || nb != 0) begin errors++;
            $display("FAIL mid_restart: beats %0d bad %0d want %0d,0 (first idx %0d)", beat_q.size(), nb, NSI, fb); end
    endtask

    initial begin
        s_if.out_ready = 1'b1;
        test_reset();
        test_full_stream();
        test_random_ready();
        test_timeout();
        test_error_clear_start_busy();
        test_peaks();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "global timeout");
    end
endmodule
